// File: rtl/hex_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scheduler
// Description : Lets several requesters share the hex display data word.
//               Requesters write 16-bit slots into a shadow buffer through
//               valid/ready ports arbitrated round-robin. The shadow buffer is
//               copied to the live output only after a rising edge of vsync,
//               so a visible frame never shows a half-updated buffer.
// Ports       : clk        pixel clock, rising edge
//               reset      synchronous, active-high
//               req_valid  per-requester write request            [N]
//               req_addr   slot index, requester i at [i*A +: A]  [N*A]
//               req_data   slot data,  requester i at [i*W +: W]  [N*W]
//               req_ready  registered one-hot write accept        [N]
//               vsync      VGA vsync, active-high
//               data       live buffer to the hex decoder
//               commit     one-cycle pulse when data is updated
//               dirty      shadow holds writes not yet committed
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scheduler #(
  parameter int C_data_len   = 256,
  parameter int C_word_bits  = 16,
  parameter int C_requesters = 4,
  parameter int C_addr_bits  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [C_requesters-1:0]             req_valid,
  input  logic [C_requesters*C_addr_bits-1:0] req_addr,
  input  logic [C_requesters*C_word_bits-1:0] req_data,
  output logic [C_requesters-1:0]             req_ready,
  input  logic                                vsync,
  output logic [C_data_len-1:0]               data,
  output logic                                commit,
  output logic                                dirty
);

  localparam int PTR_W = (C_requesters > 1) ? $clog2(C_requesters) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                state;
  logic [C_data_len-1:0] shadow;
  logic [PTR_W-1:0]      rr;
  logic                  vsync_q;

  logic                    vsync_edge;
  logic [C_requesters-1:0] hs_vec;
  logic [C_requesters-1:0] eligible;
  logic [C_requesters-1:0] grant_vec;
  logic                    hs;
  logic                    grant_found;
  logic [PTR_W-1:0]        hs_idx;
  logic [PTR_W-1:0]        rr_next;
  logic [PTR_W-1:0]        search_base;
  logic [PTR_W-1:0]        idx;
  logic [C_addr_bits-1:0]  hs_addr;
  logic [C_word_bits-1:0]  hs_data;

  assign vsync_edge = vsync & ~vsync_q;

  always_comb begin
    hs_vec      = req_valid & req_ready;
    hs          = |hs_vec;
    hs_idx      = '0;
    hs_addr     = '0;
    hs_data     = '0;
    for (int i = 0; i < C_requesters; i++) begin
      if (hs_vec[i]) begin
        hs_idx  = PTR_W'(i);
        hs_addr = req_addr[i*C_addr_bits +: C_addr_bits];
        hs_data = req_data[i*C_word_bits +: C_word_bits];
      end
    end
    rr_next = PTR_W'((int'(hs_idx) + 1) % C_requesters);

    // The search for the next grant already uses the pointer that this
    // cycle's handshake will leave behind, so back-to-back grants to
    // different ports are possible. A port whose ready is high is excluded:
    // either it is completing now or its valid has dropped.
    search_base = hs ? rr_next : rr;
    eligible    = req_valid & ~req_ready;
    grant_found = 1'b0;
    grant_vec   = '0;
    idx         = '0;
    for (int k = 0; k < C_requesters; k++) begin
      idx = PTR_W'((int'(search_base) + k) % C_requesters);
      if (!grant_found && eligible[idx]) begin
        grant_found    = 1'b1;
        grant_vec[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      data      <= '0;
      rr        <= '0;
      vsync_q   <= 1'b1;
      req_ready <= '0;
      commit    <= 1'b0;
      dirty     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      commit  <= 1'b0;

      if (hs) begin
        shadow[int'(hs_addr)*C_word_bits +: C_word_bits] <= hs_data;
        dirty <= 1'b1;
        rr    <= rr_next;
      end

      if (state == COMMIT) begin
        // Ready is held low throughout COMMIT, so no write can race the copy
        // and clearing dirty here cannot lose a pending update.
        data      <= shadow;
        commit    <= 1'b1;
        dirty     <= 1'b0;
        req_ready <= '0;
        state     <= IDLE;
      end else if (vsync_edge && (dirty || hs)) begin
        // A write landing on the edge cycle is already in the shadow by the
        // time the copy happens in COMMIT.
        req_ready <= '0;
        state     <= COMMIT;
      end else begin
        req_ready <= grant_vec;
        state     <= grant_found ? GRANT : IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_display_scheduler
// Description : Directed self-checking bench for hex_display_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_scheduler;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [15:0]  req_addr;
  logic [63:0]  req_data;
  logic [3:0]   req_ready;
  logic         vsync;
  logic [255:0] data;
  logic         commit;
  logic         dirty;

  int checks;
  int fails;

  hex_display_scheduler #(
    .C_data_len  (256),
    .C_word_bits (16),
    .C_requesters(4),
    .C_addr_bits (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .vsync    (vsync),
    .data     (data),
    .commit   (commit),
    .dirty    (dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [3:0] a, input logic [15:0] d);
    req_valid[p]      = v;
    req_addr[p*4 +: 4]   = a;
    req_data[p*16 +: 16] = d;
  endtask

  function automatic logic [15:0] slot(input int k);
    return data[k*16 +: 16];
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Full handshake on one port; ready is sampled just after the edge, so a
  // high value means the next edge completes the transfer.
  task automatic write_port(input int p, input logic [3:0] a, input logic [15:0] d);
    logic done;
    done = 1'b0;
    set_port(p, 1'b1, a, d);
    for (int c = 0; c < 20 && !done; c++) begin
      if (req_ready[p]) done = 1'b1;
      tick();
    end
    req_valid[p] = 1'b0;
    check("write_done", done, 1'b1);
  endtask

  task automatic wait_ready(input int p);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (req_ready[p]) seen = 1'b1;
      else tick();
    end
    check("ready_seen", seen, 1'b1);
  endtask

  task automatic do_commit();
    vsync = 1'b1;
    tick();
    check("commit_ready_low", req_ready, 4'b0000);
    check("commit_not_yet", commit, 1'b0);
    tick();
    check("commit_pulse", commit, 1'b1);
    check("commit_clean", dirty, 1'b0);
    vsync = 1'b0;
    tick();
    check("commit_one_cycle", commit, 1'b0);
  endtask

  int           order [5];
  int           n;
  int           p;
  logic [255:0] exp;

  initial begin
    checks    = 0;
    fails     = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    vsync     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_data", data, '0);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_commit", commit, 1'b0);
    check("rst_dirty", dirty, 1'b0);

    // 1: single write stays hidden until vsync
    write_port(0, 4'd3, 16'hBEEF);
    tick();
    tick();
    check("t1_data_hidden", data, '0);
    check("t1_dirty", dirty, 1'b1);
    do_commit();
    check("t1_slot3", slot(3), 16'hBEEF);

    // 2: all ports contending, grants rotate 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_port(i, 1'b1, 4'(4 + i), 16'hA000 + 16'(i));
    n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      check("t2_onehot", $onehot0(req_ready), 1'b1);
      if (req_ready != 4'b0000) begin
        p        = onehot_idx(req_ready);
        order[n] = p;
        n++;
        tick();
        if (p == 0 && n == 1) set_port(0, 1'b1, 4'd8, 16'hA004);
        else req_valid[p] = 1'b0;
      end else begin
        tick();
      end
    end
    check("t2_grants", n, 5);
    check("t2_order0", order[0], 0);
    check("t2_order1", order[1], 1);
    check("t2_order2", order[2], 2);
    check("t2_order3", order[3], 3);
    check("t2_order4", order[4], 0);
    do_commit();
    check("t2_slot4", slot(4), 16'hA000);
    check("t2_slot5", slot(5), 16'hA001);
    check("t2_slot6", slot(6), 16'hA002);
    check("t2_slot7", slot(7), 16'hA003);
    check("t2_slot8", slot(8), 16'hA004);

    // 3: same slot from two ports; pointer sits at 1, so port2 lands last
    set_port(1, 1'b1, 4'd2, 16'h1111);
    set_port(2, 1'b1, 4'd2, 16'h2222);
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      check("t3_onehot", $onehot0(req_ready), 1'b1);
      if (req_ready != 4'b0000) begin
        p        = onehot_idx(req_ready);
        order[n] = p;
        n++;
        tick();
        req_valid[p] = 1'b0;
      end else begin
        tick();
      end
    end
    check("t3_first", order[0], 1);
    check("t3_second", order[1], 2);
    do_commit();
    check("t3_slot2", slot(2), 16'h2222);

    // 4: handshake on the vsync edge, plus a write stalled by COMMIT
    set_port(0, 1'b1, 4'd0, 16'h1234);
    wait_ready(0);
    vsync = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    check("t4_ready_low", req_ready, 4'b0000);
    check("t4_commit_wait", commit, 1'b0);
    check("t4_dirty", dirty, 1'b1);
    set_port(3, 1'b1, 4'd9, 16'h5555);
    tick();
    check("t4_commit", commit, 1'b1);
    check("t4_slot0", slot(0), 16'h1234);
    check("t4_stalled", req_ready, 4'b0000);
    vsync = 1'b0;
    tick();
    check("t4_late_grant", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    check("t4_redirty", dirty, 1'b1);
    check("t4_slot9_hidden", slot(9), 16'h0000);
    do_commit();
    check("t4_slot9", slot(9), 16'h5555);

    // 5: vsync edge with nothing pending
    exp           = '0;
    exp[15:0]     = 16'h1234;
    exp[47:32]    = 16'h2222;
    exp[79:64]    = 16'hA000;
    exp[95:80]    = 16'hA001;
    exp[111:96]   = 16'hA002;
    exp[127:112]  = 16'hA003;
    exp[143:128]  = 16'hA004;
    exp[159:144]  = 16'h5555;
    check("t5_clean", dirty, 1'b0);
    vsync = 1'b1;
    tick();
    check("t5_no_commit_a", commit, 1'b0);
    tick();
    check("t5_no_commit_b", commit, 1'b0);
    check("t5_data", data, exp);
    vsync = 1'b0;
    tick();

    // 6: reset while port0 holds ready; pointer left at 2 beforehand
    write_port(1, 4'd11, 16'h9999);
    set_port(0, 1'b1, 4'd1, 16'h7777);
    wait_ready(0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_data", data, '0);
    check("t6_dirty", dirty, 1'b0);
    check("t6_ready", req_ready, 4'b0000);
    check("t6_commit", commit, 1'b0);
    set_port(2, 1'b1, 4'd10, 16'h8888);
    tick();
    check("t6_first_grant", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    check("t6_second_grant", req_ready, 4'b0100);
    tick();
    req_valid[2] = 1'b0;
    do_commit();
    exp           = '0;
    exp[31:16]    = 16'h7777;
    exp[175:160]  = 16'h8888;
    check("t6_data_after", data, exp);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
